// File: rtl/rom_boot_loader.sv
// Boot-time copy engine: streams the boot image from ROM into RAM through a ready/valid
// write port, holds the CPU in reset until done and keeps an additive image checksum.
module rom_boot_loader #(
    parameter logic [15:0] ROM_BASE   = 16'h0040,
    parameter logic [15:0] RAM_BASE   = 16'h0000,
    parameter int unsigned WORD_COUNT = 64
) (
    input  logic        clk,
    input  logic        reset,
    output logic [15:0] rom_address,
    input  logic [31:0] rom_data,
    output logic [15:0] ram_address,
    output logic [31:0] ram_data,
    output logic        ram_write,
    input  logic        ram_ready,
    input  logic        reload,
    output logic        cpu_reset,
    output logic        done,
    output logic [31:0] checksum
);

    typedef enum logic [1:0] {
        StFetch,
        StWrite,
        StDone
    } state_e;

    localparam logic [13:0] LastIdx = 14'(WORD_COUNT);

    state_e      state_q;
    logic [13:0] idx_q;
    logic [13:0] idx_next;
    logic [15:0] ram_address_q;
    logic [31:0] ram_data_q;
    logic [31:0] checksum_q;

    assign idx_next = idx_q + 14'd1;

    // Word index times four is exactly 16 bits, so the sum wraps mod 2^16 for free.
    assign rom_address = ROM_BASE + {idx_q, 2'b00};

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q       <= StFetch;
            idx_q         <= '0;
            checksum_q    <= '0;
            ram_address_q <= RAM_BASE;
            ram_data_q    <= '0;
        end else begin
            unique case (state_q)
                StFetch: begin
                    if (WORD_COUNT == 0) begin
                        state_q <= StDone;
                    end else begin
                        ram_data_q    <= rom_data;
                        ram_address_q <= RAM_BASE + {idx_q, 2'b00};
                        state_q       <= StWrite;
                    end
                end
                StWrite: begin
                    if (ram_ready) begin
                        checksum_q <= checksum_q + ram_data_q;
                        idx_q      <= idx_next;
                        state_q    <= (idx_next == LastIdx) ? StDone : StFetch;
                    end
                end
                StDone: begin
                    if (reload) begin
                        idx_q      <= '0;
                        checksum_q <= '0;
                        state_q    <= StFetch;
                    end
                end
                default: state_q <= StFetch;
            endcase
        end
    end

    assign ram_address = ram_address_q;
    assign ram_data    = ram_data_q;
    assign checksum    = checksum_q;
    assign ram_write   = (state_q == StWrite);
    assign done        = (state_q == StDone);
    assign cpu_reset   = (state_q != StDone);

endmodule
